// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared RGB332 slices, colour constants and fill FSM encoding
package vga_pkg;

    // RGB332 pixel byte
    typedef logic [7:0] rgb332_t;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    localparam rgb332_t BLACK = 8'h00;
    localparam rgb332_t WHITE = 8'hFF;

    typedef enum logic {
        FB_FILL = 1'b0,
        FB_IDLE = 1'b1
    } fb_state_t;

endpackage

// File: rtl/vga_tile_ram.sv
// rtl/vga_tile_ram.sv - simple dual-port tile store, one write port and one registered read port
module vga_tile_ram
    import vga_pkg::*;
#(
    parameter int DEPTH  = 1200,
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  rgb332_t           i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output rgb332_t           o_rdata
);

    rgb332_t r_mem [DEPTH];
    rgb332_t r_rdata;

    // Write and registered read share one edge, so a same-address read sees the old byte
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_tile_fb.sv
// rtl/vga_tile_fb.sv - tile framebuffer with write port, fill engine and 2-clock read pipeline; VGA_TILE_GRID_EN adds white tile-edge grid
module vga_tile_fb
    import vga_pkg::*;
#(
    parameter int      TILE_SHIFT = 4,
    parameter int      COLS       = 40,
    parameter int      ROWS       = 30,
    parameter rgb332_t FILL_COLOR = 8'hE0,
    localparam int     ADDR_W     = $clog2(COLS*ROWS)
) (
    input  logic              VGA_CLK,
    input  logic              RST_N,
    input  logic [9:0]        X,
    input  logic [9:0]        Y,
    input  logic              valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_err,
    input  logic              fill_req,
    input  logic [7:0]        fill_color,
    output logic              busy,
    output logic [2:0]        VGA_R,
    output logic [2:0]        VGA_G,
    output logic [1:0]        VGA_B
);

    localparam int                TW     = 10 - TILE_SHIFT;
    localparam int                NTILES = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(NTILES - 1);
    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [ADDR_W:0]   NT_W   = (ADDR_W+1)'(NTILES);

    fb_state_t         r_state;
    fb_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    rgb332_t           r_color;
    logic              r_wr_err;
    logic              r_on;
    rgb332_t           r_pix;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    rgb332_t           w_wdata;
    logic              w_wr_oor;
    logic [TW-1:0]     w_col;
    logic [TW-1:0]     w_row;
    logic              w_in_grid;
    logic [ADDR_W-1:0] w_raddr;
    rgb332_t           w_rdata;
    rgb332_t           w_pix_nxt;

    assign w_wr_oor = ({1'b0, wr_addr} >= NT_W);

    // Fill state register
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= FB_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake and RAM write port steering
    always_comb begin
        w_state_nxt = r_state;
        wr_ready    = 1'b0;
        busy        = 1'b0;
        w_we        = 1'b0;
        w_waddr     = wr_addr;
        w_wdata     = wr_data;
        case (r_state)
            FB_FILL: begin
                busy    = 1'b1;
                w_we    = 1'b1;
                w_waddr = r_cnt;
                w_wdata = r_color;
                if (r_cnt == LAST) begin
                    w_state_nxt = FB_IDLE;
                end
            end
            FB_IDLE: begin
                if (fill_req) begin
                    w_state_nxt = FB_FILL;
                end else begin
                    wr_ready = 1'b1;
                    w_we     = wr_valid & ~w_wr_oor;
                end
            end
            default: w_state_nxt = FB_FILL;
        endcase
    end

    // Fill address counter, latched fill colour and out-of-range write flag
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt    <= '0;
            r_color  <= FILL_COLOR;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_valid & wr_ready & w_wr_oor;
            if (r_state == FB_FILL) begin
                r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
            end else if (fill_req) begin
                r_cnt   <= '0;
                r_color <= fill_color;
            end
        end
    end

    assign wr_err = r_wr_err;

    // Grid bounds are checked on the tile coordinates so the multiply never sees an off-screen tile
    assign w_col     = X[9:TILE_SHIFT];
    assign w_row     = Y[9:TILE_SHIFT];
    assign w_in_grid = (32'(w_col) < COLS) && (32'(w_row) < ROWS);
    assign w_raddr   = w_in_grid ? (ADDR_W'(w_row) * COLS_A + ADDR_W'(w_col)) : '0;

    vga_tile_ram #(
        .DEPTH  (NTILES),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (VGA_CLK),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

`ifdef VGA_TILE_GRID_EN
    logic r_grid;

    // Tile-edge flag travels alongside the RAM read
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_grid <= 1'b0;
        end else begin
            r_grid <= (X[TILE_SHIFT-1:0] == '0) || (Y[TILE_SHIFT-1:0] == '0);
        end
    end

    assign w_pix_nxt = r_on ? (r_grid ? WHITE : w_rdata) : BLACK;
`else
    logic w_unused_lsb;
    assign w_unused_lsb = ^{X[TILE_SHIFT-1:0], Y[TILE_SHIFT-1:0]};
    assign w_pix_nxt    = r_on ? w_rdata : BLACK;
`endif

    // Pixel enable captured with the RAM read; blanked outside the visible grid or while filling
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_on <= 1'b0;
        end else begin
            r_on <= valid & w_in_grid & (r_state == FB_IDLE);
        end
    end

    // Registered DAC outputs
    always_ff @(posedge VGA_CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_pix <= BLACK;
        end else begin
            r_pix <= w_pix_nxt;
        end
    end

    assign VGA_R = r_pix[R_MSB:R_LSB];
    assign VGA_G = r_pix[G_MSB:G_LSB];
    assign VGA_B = r_pix[B_MSB:B_LSB];

endmodule

// File: tb/tb_vga_tile_fb.sv
// tb/tb_vga_tile_fb.sv - directed self-checking bench for vga_tile_fb
module tb_vga_tile_fb;

    logic        VGA_CLK = 1'b0;
    logic        RST_N;
    logic [9:0]  X;
    logic [9:0]  Y;
    logic        valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_err;
    logic        fill_req;
    logic [7:0]  fill_color;
    logic        busy;
    logic [2:0]  VGA_R;
    logic [2:0]  VGA_G;
    logic [1:0]  VGA_B;
    logic [7:0]  w_pix;

    int n_checks = 0;
    int n_errors = 0;

    int cs [6] = '{0, 39, 20, 7, 13, 39};
    int rs [6] = '{0, 29, 15, 3, 22, 0};

    assign w_pix = {VGA_R, VGA_G, VGA_B};

    always #5 VGA_CLK = ~VGA_CLK;

    vga_tile_fb dut (
        .VGA_CLK    (VGA_CLK),
        .RST_N      (RST_N),
        .X          (X),
        .Y          (Y),
        .valid      (valid),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_err     (wr_err),
        .fill_req   (fill_req),
        .fill_color (fill_color),
        .busy       (busy),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge VGA_CLK);
            #1;
        end
    endtask

    task automatic rd(input int x, input int y, input logic v, output logic [7:0] p);
        X     = 10'(x);
        Y     = 10'(y);
        valid = v;
        tick(2);
        p = w_pix;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_valid = 1'b1;
        wr_addr  = 11'(a);
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // Full fill from its first cycle: busy high 1200 cycles then drops
    task automatic fill_wait(input string tag);
        tick(1199);
        chk({tag, "_busy_1199"}, busy, 1);
        tick();
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_ready_done"}, wr_ready, 1);
    endtask

    logic [7:0] p;

    initial begin
        RST_N = 1'b0; X = '0; Y = '0; valid = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        fill_req = 1'b0; fill_color = '0;
        tick(3);
        chk("rst_pix", w_pix, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ready", wr_ready, 0);
        chk("rst_err", wr_err, 0);

        // 1: power-on fill with valid scan
        X = 10'd8; Y = 10'd8; valid = 1'b1;
        RST_N = 1'b1;
        tick(600);
        chk("t1_fill_pix", w_pix, 0);
        chk("t1_fill_ready", wr_ready, 0);
        tick(599);
        chk("t1_busy_1199", busy, 1);
        tick();
        chk("t1_busy_done", busy, 0);
        for (int i = 0; i < 6; i++) begin
            rd(cs[i]*16 + 8, rs[i]*16 + 8, 1'b1, p);
            chk($sformatf("t1_tile_%0d_%0d", cs[i], rs[i]), p, 8'hE0);
        end

        // 2: single write then read tile (1,1)
        chk("t2_ready", wr_ready, 1);
        wr(41, 8'h1C);
        rd(17, 17, 1'b1, p);
        chk("t2_tile41", p, 8'h1C);
        rd(15, 17, 1'b1, p);
        chk("t2_tile40", p, 8'hE0);

        // read-before-write on the same tile
        X = 10'd20; Y = 10'd20; valid = 1'b1;
        wr(41, 8'h55);
        tick();
        chk("t2_rbw_old", w_pix, 8'h1C);
        rd(20, 20, 1'b1, p);
        chk("t2_rbw_new", p, 8'h55);

        // 3: out-of-range write, then last tile
        wr(1200, 8'h77);
        chk("t3_err_pulse", wr_err, 1);
        tick();
        chk("t3_err_clear", wr_err, 0);
        rd(8, 8, 1'b1, p);
        chk("t3_tile0", p, 8'hE0);
        wr(1199, 8'h4A);
        chk("t3_no_err", wr_err, 0);
        rd(625, 465, 1'b1, p);
        chk("t3_tile1199", p, 8'h4A);

        // 4: fill request collides with a held write
        fill_req = 1'b1; fill_color = 8'h03;
        wr_valid = 1'b1; wr_addr = 11'd5; wr_data = 8'hAA;
        #1;
        chk("t4_ready_collide", wr_ready, 0);
        chk("t4_busy_pre", busy, 0);
        tick();
        fill_req = 1'b0;
        chk("t4_busy_start", busy, 1);
        chk("t4_ready_fill", wr_ready, 0);
        fill_wait("t4");
        tick();
        wr_valid = 1'b0;
        rd(8, 8, 1'b1, p);
        chk("t4_tile0", p, 8'h03);
        rd(88, 8, 1'b1, p);
        chk("t4_tile5_held_wr", p, 8'hAA);
        rd(328, 248, 1'b1, p);
        chk("t4_tile_20_15", p, 8'h03);

        // 5: blanking outside grid / valid, and grid overlay
        rd(650, 8, 1'b1, p);
        chk("t5_col40", p, 0);
        rd(8, 480, 1'b1, p);
        chk("t5_row30", p, 0);
        rd(8, 8, 1'b0, p);
        chk("t5_invalid", p, 0);
        rd(32, 5, 1'b1, p);
`ifdef VGA_TILE_GRID_EN
        chk("t5_grid", p, 8'hFF);
`else
        chk("t5_nogrid", p, 8'h03);
`endif

        // asynchronous clear of a live output
        rd(88, 8, 1'b1, p);
        chk("t6_pre_async", p, 8'hAA);
        RST_N = 1'b0;
        #2;
        chk("t6_async_pix", w_pix, 0);
        chk("t6_async_busy", busy, 1);
        tick();
        RST_N = 1'b1;
        fill_wait("t6a");

        // 6: reset in the middle of a requested fill
        fill_req = 1'b1; fill_color = 8'h1C;
        tick();
        fill_req = 1'b0;
        tick(500);
        RST_N = 1'b0;
        #2;
        chk("t6_mid_busy", busy, 1);
        chk("t6_mid_ready", wr_ready, 0);
        chk("t6_mid_pix", w_pix, 0);
        tick();
        RST_N = 1'b1;
        fill_wait("t6b");
        rd(8, 8, 1'b1, p);
        chk("t6_tile0", p, 8'hE0);
        rd(312, 200, 1'b1, p);
        chk("t6_tile499", p, 8'hE0);
        rd(8, 408, 1'b1, p);
        chk("t6_tile1000", p, 8'hE0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
